// File: rtl/sa_max_ctrl_pkg.sv
// Shared types and constants for the max-pool systolic array controller.
// State enum, FP16 pad value and a width helper.
package sa_max_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_PRELOAD,
        S_STREAM,
        S_DRAIN,
        S_LOAD,
        S_DONE
    } state_e;

    localparam logic [15:0] FP16_NEG_INF = 16'hFC00;

    function automatic int max_w(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sa_ctrl_counter.sv
// Loadable down-counter shared by beat counting and drain timing.
// Exposes zero and last (count == 1) flags.
module sa_ctrl_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero,
    output logic         last
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign zero = (cnt_q == '0);
    assign last = (cnt_q == W'(1));

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && !zero) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/sa_max_ctrl.sv
// Job sequencer for the max-pool systolic array (clear/preload/stream/drain/load).
// Optional perf counters enabled by defining SA_MAX_CTRL_PERF_EN.
module sa_max_ctrl
    import sa_max_ctrl_pkg::*;
#(
    parameter int ARR_DIM = 8,
    parameter int LEN_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic             cfg_preload,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             abort,
    output logic             reg_clear,
    output logic             pipeline_en,
    output logic             preload_en,
    output logic             result_load,
    output logic             pad_en,
    output logic             done_valid,
    input  logic             done_ready,
`ifdef SA_MAX_CTRL_PERF_EN
    output logic [31:0]      perf_busy_cyc,
    output logic [31:0]      perf_stall_cyc,
`endif
    output logic             busy
);

    localparam int     DRAIN_CYC  = 2 * (ARR_DIM - 1);
    localparam int     CNT_W      = max_w(LEN_W, 8);
    localparam state_e DRAIN_NEXT = (DRAIN_CYC == 0) ? S_LOAD : S_DRAIN;

    state_e             state_q, state_d;
    logic               preload_q, preload_d;
    logic               cnt_load, cnt_dec, cnt_zero, cnt_last;
    logic [CNT_W-1:0]   cnt_val;
    logic               go_drain;
    logic               kill;
    logic               start_acc;

    assign kill      = abort && (state_q != S_IDLE);
    assign start_acc = (state_q == S_IDLE) && start_valid;

    always_comb begin
        state_d   = state_q;
        preload_d = preload_q;
        cnt_load  = 1'b0;
        cnt_val   = '0;
        cnt_dec   = 1'b0;
        go_drain  = 1'b0;
        if (kill) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: if (start_valid) begin
                    state_d   = S_CLEAR;
                    preload_d = cfg_preload;
                    cnt_load  = 1'b1;
                    cnt_val   = CNT_W'(cfg_len);
                end
                S_CLEAR: begin
                    if (preload_q)     state_d = S_PRELOAD;
                    else if (cnt_zero) go_drain = 1'b1;
                    else               state_d = S_STREAM;
                end
                S_PRELOAD: begin
                    if (cnt_zero) go_drain = 1'b1;
                    else          state_d = S_STREAM;
                end
                S_STREAM: if (in_valid) begin
                    cnt_dec  = 1'b1;
                    go_drain = cnt_last;
                end
                S_DRAIN: begin
                    cnt_dec = 1'b1;
                    if (cnt_last) state_d = S_LOAD;
                end
                S_LOAD: state_d = S_DONE;
                S_DONE: if (done_ready) state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
            // Drain length reuses the beat counter once streaming is over
            if (go_drain) begin
                cnt_load = 1'b1;
                cnt_val  = CNT_W'(DRAIN_CYC);
                state_d  = DRAIN_NEXT;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            preload_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            preload_q <= preload_d;
        end
    end

    sa_ctrl_counter #(.W(CNT_W)) u_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cnt_load),
        .load_val (cnt_val),
        .dec      (cnt_dec),
        .zero     (cnt_zero),
        .last     (cnt_last)
    );

    assign start_ready = (state_q == S_IDLE);
    assign busy        = (state_q != S_IDLE);
    assign reg_clear   = (state_q == S_CLEAR) || kill;
    assign in_ready    = !kill && (state_q == S_STREAM);
    assign preload_en  = !kill && (state_q == S_PRELOAD);
    assign pad_en      = !kill && (state_q == S_DRAIN);
    assign result_load = !kill && (state_q == S_LOAD);
    assign done_valid  = !kill && (state_q == S_DONE);
    assign pipeline_en = !kill && ((state_q == S_PRELOAD) ||
                                   (state_q == S_DRAIN) ||
                                   ((state_q == S_STREAM) && in_valid));

`ifdef SA_MAX_CTRL_PERF_EN
    logic [31:0] pbusy_q, pbusy_d;
    logic [31:0] pstall_q, pstall_d;

    always_comb begin
        pbusy_d  = pbusy_q;
        pstall_d = pstall_q;
        if (start_acc) begin
            pbusy_d  = '0;
            pstall_d = '0;
        end else begin
            if (busy && !(&pbusy_q))
                pbusy_d = pbusy_q + 32'd1;
            if ((state_q == S_STREAM) && !in_valid && !(&pstall_q))
                pstall_d = pstall_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pbusy_q  <= '0;
            pstall_q <= '0;
        end else begin
            pbusy_q  <= pbusy_d;
            pstall_q <= pstall_d;
        end
    end

    assign perf_busy_cyc  = pbusy_q;
    assign perf_stall_cyc = pstall_q;
`else
    logic unused_start_acc;
    assign unused_start_acc = start_acc;
`endif

endmodule
